// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon decoder front end.
// The package holds the state encoding, the field constants and the elaboration-time GF helpers.
package rs_pkg;

   localparam int RS_T = 8;
   localparam int RS_NSYN = 16;
   localparam int RS_SYM_W = 8;
   localparam logic [8:0] GF_PRIM_POLY = 9'h11D;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DONE
   } synd_state_e;

   // Shift-and-add multiply; the carry out of bit 7 is folded back through the field polynomial
   function automatic logic [RS_SYM_W-1:0] gf_mul(input logic [RS_SYM_W-1:0] a,
                                                  input logic [RS_SYM_W-1:0] b,
                                                  input logic [8:0] poly);
      logic [RS_SYM_W-1:0] p;
      logic [RS_SYM_W-1:0] x;
      logic [8:0] t;
      p = '0;
      x = a;
      for (int k = 0; k < RS_SYM_W; k++) begin
         if (b[k]) p = p ^ x;
         t = {x, 1'b0};
         if (t[8]) t = t ^ poly;
         x = t[7:0];
      end
      return p;
   endfunction

   function automatic logic [RS_SYM_W-1:0] gf_alpha_pow(input int k, input logic [8:0] poly);
      logic [RS_SYM_W-1:0] r;
      r = 8'h01;
      for (int n = 0; n < (k % 255); n++) r = gf_mul(r, 8'h02, poly);
      return r;
   endfunction

endpackage

// File: rtl/rs_gf_mul_const.sv
// Multiply an 8-bit symbol by a fixed GF(2^8) constant.
// Each input bit selects one precomputed column, so the result is a pure XOR tree.
module rs_gf_mul_const
   import rs_pkg::*;
#(
   parameter logic [RS_SYM_W-1:0] CONST = 8'h01,
   parameter logic [8:0] PRIM_POLY = GF_PRIM_POLY
) (
   input  logic [RS_SYM_W-1:0] din,
   output logic [RS_SYM_W-1:0] dout
);

   always_comb begin
      dout = '0;
      for (int j = 0; j < RS_SYM_W; j++) begin
         if (din[j]) dout = dout ^ gf_mul(CONST, RS_SYM_W'(1 << j), PRIM_POLY);
      end
   end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator feeding the Berlekamp-Massey stage (Horner accumulation per syndrome).
// Optional macro RS_SYND_ZERO_FLAG_EN adds the registered no_err output (all syndromes zero).
module rs_syndrome_calc
   import rs_pkg::*;
#(
   parameter int CW_LEN = 255,
   parameter int FCR = 0,
   parameter logic [8:0] PRIM_POLY = GF_PRIM_POLY
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_sof,
   input  logic [RS_SYM_W-1:0] in_data,
   output logic [RS_SYM_W-1:0] Sm1,
   output logic [RS_SYM_W-1:0] Sm2,
   output logic [RS_SYM_W-1:0] Sm3,
   output logic [RS_SYM_W-1:0] Sm4,
   output logic [RS_SYM_W-1:0] Sm5,
   output logic [RS_SYM_W-1:0] Sm6,
   output logic [RS_SYM_W-1:0] Sm7,
   output logic [RS_SYM_W-1:0] Sm8,
   output logic [RS_SYM_W-1:0] Sm9,
   output logic [RS_SYM_W-1:0] Sm10,
   output logic [RS_SYM_W-1:0] Sm11,
   output logic [RS_SYM_W-1:0] Sm12,
   output logic [RS_SYM_W-1:0] Sm13,
   output logic [RS_SYM_W-1:0] Sm14,
   output logic [RS_SYM_W-1:0] Sm15,
   output logic [RS_SYM_W-1:0] Sm16,
   output logic Sm_ready,
   output logic busy
`ifdef RS_SYND_ZERO_FLAG_EN
   ,
   output logic no_err
`endif
);

   localparam logic [7:0] LAST_CNT = 8'(CW_LEN - 1);

   synd_state_e state;
   logic [7:0] cnt;
   logic [RS_SYM_W-1:0] acc      [RS_NSYN];
   logic [RS_SYM_W-1:0] acc_src  [RS_NSYN];
   logic [RS_SYM_W-1:0] mul_out  [RS_NSYN];
   logic [RS_SYM_W-1:0] acc_next [RS_NSYN];
   logic [RS_SYM_W-1:0] sm_q     [RS_NSYN];
   logic first_byte;
   logic last_byte;

   // Outside ACCUM every byte opens a codeword, and in_sof inside ACCUM restarts one
   assign first_byte = (state != ST_ACCUM) || in_sof;
   assign last_byte  = in_valid && (state == ST_ACCUM) && !in_sof && (cnt == LAST_CNT);

   genvar g;
   generate
      for (g = 0; g < RS_NSYN; g++) begin : g_syn
         assign acc_src[g] = first_byte ? '0 : acc[g];
         rs_gf_mul_const #(
            .CONST(gf_alpha_pow(FCR + g, PRIM_POLY)),
            .PRIM_POLY(PRIM_POLY)
         ) u_mul (
            .din(acc_src[g]),
            .dout(mul_out[g])
         );
         assign acc_next[g] = mul_out[g] ^ in_data;
      end
   endgenerate

`ifdef RS_SYND_ZERO_FLAG_EN
   logic all_zero;
   always_comb begin
      all_zero = 1'b1;
      for (int i = 0; i < RS_NSYN; i++) begin
         if (acc_next[i] != '0) all_zero = 1'b0;
      end
   end
`endif

   // The output bank is loaded with the final Horner step on the last byte, so it is valid in the DONE cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         Sm_ready <= 1'b0;
         for (int i = 0; i < RS_NSYN; i++) begin
            acc[i]  <= '0;
            sm_q[i] <= '0;
         end
`ifdef RS_SYND_ZERO_FLAG_EN
         no_err <= 1'b0;
`endif
      end else begin
         Sm_ready <= 1'b0;
         if (in_valid) begin
            for (int i = 0; i < RS_NSYN; i++) acc[i] <= acc_next[i];
         end
         case (state)
            ST_IDLE, ST_DONE: begin
               if (in_valid) begin
                  state <= ST_ACCUM;
                  cnt   <= 8'd1;
                  busy  <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ACCUM: begin
               if (last_byte) begin
                  state    <= ST_DONE;
                  cnt      <= '0;
                  busy     <= 1'b0;
                  Sm_ready <= 1'b1;
                  for (int i = 0; i < RS_NSYN; i++) sm_q[i] <= acc_next[i];
`ifdef RS_SYND_ZERO_FLAG_EN
                  no_err <= all_zero;
`endif
               end else if (in_valid) begin
                  cnt <= in_sof ? 8'd1 : cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign Sm1  = sm_q[0];
   assign Sm2  = sm_q[1];
   assign Sm3  = sm_q[2];
   assign Sm4  = sm_q[3];
   assign Sm5  = sm_q[4];
   assign Sm6  = sm_q[5];
   assign Sm7  = sm_q[6];
   assign Sm8  = sm_q[7];
   assign Sm9  = sm_q[8];
   assign Sm10 = sm_q[9];
   assign Sm11 = sm_q[10];
   assign Sm12 = sm_q[11];
   assign Sm13 = sm_q[12];
   assign Sm14 = sm_q[13];
   assign Sm15 = sm_q[14];
   assign Sm16 = sm_q[15];

endmodule
